mem_bus_arbiter: RTL and testbench

- Shares the single 64-bit memory port between the instruction cache (demand fetch plus prefetch, already merged inside the icache) and the data cache.
- Per cycle, picks one requester and drives its command, address and data to memory. Returns the memory's accept response only to the winner.
- Records which requester owns each outstanding load tag, so returned data and tags are steered to the right cache only.
- Sits between the icache/dcache controllers and the memory model, replacing their direct connections.

---
 rtl/mem_bus_arbiter_pkg.sv | 18 +
 rtl/mem_tag_table.sv | 50 +++++
 rtl/mem_bus_arbiter.sv | 108 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: bus command encoding, port owner, defaults.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

  typedef enum logic {
    ARB_ICACHE = 1'b0,
    ARB_DCACHE = 1'b1
  } arb_owner_t;

  localparam int TAG_W_DEFAULT        = 4;
  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-load tag table: records which cache owns each accepted load tag.
module mem_tag_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  arb_owner_t       alloc_owner,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_hit,
  output arb_owner_t       lookup_owner,
  output logic             orphan_tag_err
);

  localparam int N = 1 << TAG_W;

  logic [N-1:0] valid_q;
  logic [N-1:0] owner_q;
  logic         lookup_miss;
  logic         alloc_ok;
  logic         overwrite;

  assign lookup_hit   = (lookup_tag != '0) && valid_q[lookup_tag];
  assign lookup_miss  = (lookup_tag != '0) && !valid_q[lookup_tag];
  assign lookup_owner = arb_owner_t'(owner_q[lookup_tag]);
  assign alloc_ok     = alloc_en && (alloc_tag != '0);
  // Re-allocating a tag that is being returned this same cycle is legal reuse.
  assign overwrite    = alloc_ok && valid_q[alloc_tag] &&
                        !(lookup_hit && (lookup_tag == alloc_tag));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q        <= '0;
      owner_q        <= '0;
      orphan_tag_err <= 1'b0;
    end else begin
      if (lookup_hit) valid_q[lookup_tag] <= 1'b0;
      // Allocation is written after the free so it wins on the same tag.
      if (alloc_ok) begin
        valid_q[alloc_tag] <= 1'b1;
        owner_q[alloc_tag] <= alloc_owner;
      end
      if (lookup_miss || overwrite) orphan_tag_err <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-way arbiter sharing the memory port between icache and dcache, with
// starvation protection for the icache and tag-based return steering.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int TAG_W        = TAG_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       Icache2arb_command,
  input  logic [XLEN-1:0]  Icache2arb_addr,
  input  logic [1:0]       Dcache2arb_command,
  input  logic [XLEN-1:0]  Dcache2arb_addr,
  input  logic [63:0]      Dcache2arb_data,
  input  logic [TAG_W-1:0] mem2arb_response,
  input  logic [63:0]      mem2arb_data,
  input  logic [TAG_W-1:0] mem2arb_tag,
  output logic [1:0]       arb2mem_command,
  output logic [XLEN-1:0]  arb2mem_addr,
  output logic [63:0]      arb2mem_data,
  output logic [TAG_W-1:0] arb2Icache_response,
  output logic [63:0]      arb2Icache_data,
  output logic [TAG_W-1:0] arb2Icache_tag,
  output logic [TAG_W-1:0] arb2Dcache_response,
  output logic [63:0]      arb2Dcache_data,
  output logic [TAG_W-1:0] arb2Dcache_tag,
  output logic             grant_dcache,
  output logic             orphan_tag_err
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve_cnt;
  logic            i_req, d_req, starved, d_win, i_win;
  logic            alloc_en;
  logic            ret_hit;
  arb_owner_t      ret_owner;

  assign i_req   = (Icache2arb_command != BUS_NONE);
  assign d_req   = (Dcache2arb_command != BUS_NONE);
  assign starved = (starve_cnt == SC_W'(STARVE_LIMIT));
  assign d_win   = d_req && !(i_req && starved);
  assign i_win   = i_req && !d_win;

  // Handshake: a request is accepted only in the cycle the winner sees a nonzero
  // response; otherwise the requester keeps its command asserted.
  always_comb begin
    arb2mem_command     = BUS_NONE;
    arb2mem_addr        = '0;
    arb2mem_data        = '0;
    arb2Icache_response = '0;
    arb2Dcache_response = '0;
    arb2Icache_data     = '0;
    arb2Icache_tag      = '0;
    arb2Dcache_data     = '0;
    arb2Dcache_tag      = '0;
    grant_dcache        = 1'b0;
    if (reset) begin
      grant_dcache = d_win;
      if (d_win) begin
        arb2mem_command     = Dcache2arb_command;
        arb2mem_addr        = Dcache2arb_addr;
        arb2mem_data        = Dcache2arb_data;
        arb2Dcache_response = mem2arb_response;
      end else if (i_win) begin
        arb2mem_command     = Icache2arb_command;
        arb2mem_addr        = Icache2arb_addr;
        arb2Icache_response = mem2arb_response;
      end
      if (ret_hit && (ret_owner == ARB_DCACHE)) begin
        arb2Dcache_tag  = mem2arb_tag;
        arb2Dcache_data = mem2arb_data;
      end else if (ret_hit) begin
        arb2Icache_tag  = mem2arb_tag;
        arb2Icache_data = mem2arb_data;
      end
    end
  end

  assign alloc_en = (arb2mem_command == BUS_LOAD) && (mem2arb_response != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!i_req) begin
      starve_cnt <= '0;
    end else if (!i_win) begin
      if (!starved) starve_cnt <= starve_cnt + SC_W'(1);
    end else if (mem2arb_response != '0) begin
      starve_cnt <= '0;
    end
  end

  mem_tag_table #(.TAG_W(TAG_W)) u_tag_table (
    .clock         (clock),
    .reset         (reset),
    .alloc_en      (alloc_en),
    .alloc_tag     (mem2arb_response),
    .alloc_owner   (d_win ? ARB_DCACHE : ARB_ICACHE),
    .lookup_tag    (mem2arb_tag),
    .lookup_hit    (ret_hit),
    .lookup_owner  (ret_owner),
    .orphan_tag_err(orphan_tag_err)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random traffic
// against a table-based reference model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int LIMIT = 4;
  localparam int NT    = 16;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]       Icache2arb_command = '0;
  logic [XLEN-1:0]  Icache2arb_addr    = '0;
  logic [1:0]       Dcache2arb_command = '0;
  logic [XLEN-1:0]  Dcache2arb_addr    = '0;
  logic [63:0]      Dcache2arb_data    = '0;
  logic [TAG_W-1:0] mem2arb_response   = '0;
  logic [63:0]      mem2arb_data       = '0;
  logic [TAG_W-1:0] mem2arb_tag        = '0;
  logic [1:0]       arb2mem_command;
  logic [XLEN-1:0]  arb2mem_addr;
  logic [63:0]      arb2mem_data;
  logic [TAG_W-1:0] arb2Icache_response, arb2Icache_tag;
  logic [TAG_W-1:0] arb2Dcache_response, arb2Dcache_tag;
  logic [63:0]      arb2Icache_data, arb2Dcache_data;
  logic             grant_dcache, orphan_tag_err;

  mem_bus_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .Icache2arb_command(Icache2arb_command), .Icache2arb_addr(Icache2arb_addr),
    .Dcache2arb_command(Dcache2arb_command), .Dcache2arb_addr(Dcache2arb_addr),
    .Dcache2arb_data(Dcache2arb_data),
    .mem2arb_response(mem2arb_response), .mem2arb_data(mem2arb_data),
    .mem2arb_tag(mem2arb_tag),
    .arb2mem_command(arb2mem_command), .arb2mem_addr(arb2mem_addr),
    .arb2mem_data(arb2mem_data),
    .arb2Icache_response(arb2Icache_response), .arb2Icache_data(arb2Icache_data),
    .arb2Icache_tag(arb2Icache_tag),
    .arb2Dcache_response(arb2Dcache_response), .arb2Dcache_data(arb2Dcache_data),
    .arb2Dcache_tag(arb2Dcache_tag),
    .grant_dcache(grant_dcache), .orphan_tag_err(orphan_tag_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: who owns each tag, how many times the icache has lost in a row
  bit m_valid[NT];
  bit m_owner[NT];  // 1 = dcache
  int m_starve;
  bit m_orphan;

  function automatic bit m_gd();
    bit ir, dr;
    ir = (Icache2arb_command != 2'd0);
    dr = (Dcache2arb_command != 2'd0);
    return dr && !(ir && m_starve == LIMIT);
  endfunction

  function automatic logic [1:0] m_cmd();
    return m_gd() ? Dcache2arb_command : Icache2arb_command;
  endfunction

  function automatic bit m_hit();
    return (mem2arb_tag != 0) && m_valid[mem2arb_tag];
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NT; i++) m_valid[i] <= 1'b0;
      m_starve <= 0;
      m_orphan <= 1'b0;
    end else begin
      if (mem2arb_tag != 0) begin
        if (m_valid[mem2arb_tag]) m_valid[mem2arb_tag] <= 1'b0;
        else m_orphan <= 1'b1;
      end
      if (m_cmd() == 2'd1 && mem2arb_response != 0) begin
        if (m_valid[mem2arb_response] && mem2arb_tag != mem2arb_response) m_orphan <= 1'b1;
        m_valid[mem2arb_response] <= 1'b1;
        m_owner[mem2arb_response] <= m_gd();
      end
      if (Icache2arb_command == 2'd0) m_starve <= 0;
      else if (m_gd()) m_starve <= (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else if (mem2arb_response != 0) m_starve <= 0;
    end
  end

  // compare process: every negedge, all outputs against the model
  always @(negedge clock) begin
    if (!reset) begin
      check("rst_cmd", arb2mem_command, 2'd0);
      check("rst_grant", grant_dcache, 1'b0);
      check("rst_iresp", arb2Icache_response, 0);
      check("rst_dresp", arb2Dcache_response, 0);
      check("rst_itag", arb2Icache_tag, 0);
      check("rst_dtag", arb2Dcache_tag, 0);
      check("rst_orphan", orphan_tag_err, 1'b0);
    end else begin
      check("grant", grant_dcache, m_gd());
      check("cmd", arb2mem_command, m_cmd());
      if (m_cmd() != 2'd0) begin
        check("addr", arb2mem_addr, m_gd() ? Dcache2arb_addr : Icache2arb_addr);
        check("wdata", arb2mem_data, m_gd() ? Dcache2arb_data : 64'd0);
      end
      check("iresp", arb2Icache_response,
            (Icache2arb_command != 0 && !m_gd()) ? mem2arb_response : 0);
      check("dresp", arb2Dcache_response, m_gd() ? mem2arb_response : 0);
      check("itag", arb2Icache_tag, (m_hit() && !m_owner[mem2arb_tag]) ? mem2arb_tag : 0);
      check("dtag", arb2Dcache_tag, (m_hit() && m_owner[mem2arb_tag]) ? mem2arb_tag : 0);
      check("idata", arb2Icache_data, (m_hit() && !m_owner[mem2arb_tag]) ? mem2arb_data : 0);
      check("ddata", arb2Dcache_data, (m_hit() && m_owner[mem2arb_tag]) ? mem2arb_data : 0);
      check("orphan", orphan_tag_err, m_orphan);
    end
  end

  // driver: new inputs just after a rising edge, return at the following falling edge
  task automatic apply(input logic [1:0] ic = 0, input logic [31:0] ia = 0,
                       input logic [1:0] dc = 0, input logic [31:0] da = 0,
                       input logic [63:0] dd = 0, input logic [3:0] resp = 0,
                       input logic [3:0] rtag = 0, input logic [63:0] rdata = 0);
    @(posedge clock); #1;
    Icache2arb_command = ic; Icache2arb_addr = ia;
    Dcache2arb_command = dc; Dcache2arb_addr = da; Dcache2arb_data = dd;
    mem2arb_response = resp; mem2arb_tag = rtag; mem2arb_data = rdata;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    Icache2arb_command = 0; Dcache2arb_command = 0;
    mem2arb_response = 0; mem2arb_tag = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    do_reset();

    // icache load, accepted with tag 3, returned five cycles later
    apply(2'd1, 32'h100, .resp(4'd3));
    check("t1_iresp", arb2Icache_response, 3);
    check("t1_dresp", arb2Dcache_response, 0);
    check("t1_addr", arb2mem_addr, 32'h100);
    repeat (4) apply();
    apply(.rtag(4'd3), .rdata(64'hDEAD_BEEF_0000_0003));
    check("t1_itag", arb2Icache_tag, 3);
    check("t1_idata", arb2Icache_data, 64'hDEAD_BEEF_0000_0003);
    check("t1_dtag", arb2Dcache_tag, 0);

    // both load, dcache wins with tag 2
    apply(2'd1, 32'h200, 2'd1, 32'h1000, .resp(4'd2));
    check("t2_grant", grant_dcache, 1'b1);
    check("t2_dresp", arb2Dcache_response, 2);
    check("t2_iresp", arb2Icache_response, 0);
    check("t2_addr", arb2mem_addr, 32'h1000);
    apply(.rtag(4'd2), .rdata(64'h22));
    check("t2_dtag", arb2Dcache_tag, 2);

    // tag 7 returned to icache while a dcache load reuses tag 7
    apply(2'd1, 32'h300, .resp(4'd7));
    check("t5_iresp", arb2Icache_response, 7);
    apply(.dc(2'd1), .da(32'h2000), .resp(4'd7), .rtag(4'd7), .rdata(64'h77));
    check("t5_itag", arb2Icache_tag, 7);
    check("t5_idata", arb2Icache_data, 64'h77);
    check("t5_dresp", arb2Dcache_response, 7);
    apply();
    check("t5_noerr", orphan_tag_err, 1'b0);
    apply(.rtag(4'd7), .rdata(64'h7777));
    check("t5_dtag", arb2Dcache_tag, 7);
    check("t5_itag0", arb2Icache_tag, 0);

    // continuous contention: icache forced through on the fifth cycle
    for (int k = 0; k < 6; k++) begin
      apply(2'd1, 32'h400 + k, 2'd1, 32'h3000 + k, .resp(4'(8 + k)));
      check("t3_grant", grant_dcache, (k == 4) ? 1'b0 : 1'b1);
    end
    apply();
    check("t3_noerr", orphan_tag_err, 1'b0);

    // accepted store allocates nothing; its tag coming back is an orphan
    apply(.dc(2'd2), .da(32'h4000), .dd(64'h5555), .resp(4'd5));
    check("t4_dresp", arb2Dcache_response, 5);
    check("t4_wdata", arb2mem_data, 64'h5555);
    apply(.rtag(4'd5), .rdata(64'h5));
    check("t4_itag", arb2Icache_tag, 0);
    check("t4_dtag", arb2Dcache_tag, 0);
    apply();
    check("t4_orphan", orphan_tag_err, 1'b1);

    // reset with tag 4 outstanding
    do_reset();
    apply(2'd1, 32'h500, .resp(4'd4));
    check("t6_iresp", arb2Icache_response, 4);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    check("t6_cmd_rst", arb2mem_command, 2'd0);
    check("t6_iresp_rst", arb2Icache_response, 0);
    check("t6_orphan_rst", orphan_tag_err, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    Icache2arb_command = 0; mem2arb_response = 0;
    apply(.rtag(4'd4), .rdata(64'h44));
    check("t6_itag", arb2Icache_tag, 0);
    check("t6_dtag", arb2Dcache_tag, 0);
    apply();
    check("t6_orphan", orphan_tag_err, 1'b1);

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      apply(($urandom_range(0, 3) != 0) ? 2'd1 : 2'd0, $urandom,
            2'($urandom_range(0, 2)), $urandom, {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
            ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
            {$urandom, $urandom});
      if (n == 1500) do_reset();
    end
    apply();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
